// File: rtl/load_store_unit.sv
// Load/store unit between execute and a big-endian, byte-addressed, word-wide data RAM.
// Sub-word stores do a read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse with resp_rdata/resp_err valid alongside it.
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] rd_word;

    logic        accept;
    logic        req_bad;
    logic [31:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign accept  = req_valid && req_ready;
    assign req_bad = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr > LAST_WORD);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            rd_word    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_err      <= req_bad;
                        if (req_bad)
                            state <= RESP;
                        else if (req_we && req_size == 2'b10)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    rd_word <= mem_read_data;
                    state   <= r_we ? WR : RESP;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Big-endian lane map: lane 0 is the most significant byte of the word.
    always_comb begin
        merged = rd_word;
        if (r_size == 2'b10) begin
            merged = r_wdata;
        end else if (r_size == 2'b01) begin
            if (r_addr[1]) merged[15:0]  = r_wdata[15:0];
            else           merged[31:16] = r_wdata[15:0];
        end else begin
            case (r_addr[1:0])
                2'd0:    merged[31:24] = r_wdata[7:0];
                2'd1:    merged[23:16] = r_wdata[7:0];
                2'd2:    merged[15:8]  = r_wdata[7:0];
                default: merged[7:0]   = r_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    ld_byte = rd_word[31:24];
            2'd1:    ld_byte = rd_word[23:16];
            2'd2:    ld_byte = rd_word[15:8];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = r_addr[1] ? rd_word[15:0] : rd_word[31:16];
        case (r_size)
            2'b00:   ld_ext = r_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = r_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    assign req_ready      = (state == IDLE) && !reset;
    assign mem_memread    = (state == RD);
    assign mem_memwrite   = (state == WR);
    assign resp_valid     = (state == RESP);
    assign resp_err       = (state == RESP) && r_err;
    assign resp_rdata     = (state == RESP && !r_we && !r_err) ? ld_ext : 32'h0;
    assign mem_addr       = (state == RD || state == WR) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_write_data = (state == WR) ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-wide big-endian RAM model, latency and
// RAM-access counting, extension, merge, error and mid-write reset scenarios.
module tb_load_store_unit;

    logic        CLK;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_read_data;

    logic [31:0] ram [0:255];
    logic        preload;
    int          rd_cnt;
    int          wr_cnt;
    int          checks;
    int          errors;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_read_data = ram[mem_addr[9:2]];

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[4]   <= 32'hDEADBEEF;
            ram[255] <= 32'h11223344;
        end else begin
            if (mem_memwrite) begin
                ram[mem_addr[9:2]] <= mem_write_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_memread) rd_cnt <= rd_cnt + 1;
        end
    end

    // Drives one request and waits (bounded) for its response; lat=0 means no response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int nrd, output int nwr);
        int rd0, wr0;
        @(negedge CLK);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge CLK);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; rdata = 32'hx; err = 1'bx;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (resp_valid) begin
                lat = cyc; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic test_reset;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        rd_cnt = 0; wr_cnt = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_memread, mem_memwrite} !== 5'b0 ||
            resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h exp all 0",
                     req_ready, resp_valid, resp_err, mem_memread, mem_memwrite,
                     resp_rdata, mem_addr, mem_write_data);
        end
        preload = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b exp 1", req_ready);
        end
    endtask

    task automatic test_load_word;
        int lat, nrd, nwr; logic [31:0] d; logic e;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr);
        checks++;
        if (lat !== 2 || d !== 32'hDEADBEEF || e !== 1'b0 || nrd !== 1 || nwr !== 0) begin
            errors++;
            $display("FAIL lw_0x10 lat=%0d data=%h err=%b rd=%0d wr=%0d exp 2 deadbeef 0 1 0",
                     lat, d, e, nrd, nwr);
        end
        @(negedge CLK);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_pulse rv=%b ready=%b exp 0 1", resp_valid, req_ready);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, d, e, nrd, nwr);
        checks++;
        if (lat !== 2 || d !== 32'h11223344 || e !== 1'b0) begin
            errors++;
            $display("FAIL lw_last_word lat=%0d data=%h err=%b exp 2 11223344 0", lat, d, e);
        end
    endtask

    task automatic test_loads;
        logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        us   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad   [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
        logic [31:0] expd [4] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFBEEF, 32'h0000DEAD};
        int lat, nrd, nwr; logic [31:0] d; logic e;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], us[i], ad[i], 32'hFFFFFFFF, lat, d, e, nrd, nwr);
            checks++;
            if (lat !== 2 || d !== expd[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d lat=%0d data=%h err=%b exp 2 %h 0", i, lat, d, e, expd[i]);
            end
        end
    endtask

    task automatic test_store_byte;
        int lat, nrd, nwr; logic [31:0] d; logic e;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, lat, d, e, nrd, nwr);
        @(negedge CLK);
        checks++;
        if (lat !== 3 || d !== 32'h0 || e !== 1'b0 || nrd !== 1 || nwr !== 1) begin
            errors++;
            $display("FAIL sb_0x11 lat=%0d data=%h err=%b rd=%0d wr=%0d exp 3 0 0 1 1",
                     lat, d, e, nrd, nwr);
        end
        checks++;
        if (ram[4] !== 32'hDE55BEEF) begin
            errors++; $display("FAIL sb_ram got %h exp de55beef", ram[4]);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000A5C3, lat, d, e, nrd, nwr);
        @(negedge CLK);
        checks++;
        if (lat !== 3 || ram[4] !== 32'hDE55A5C3) begin
            errors++; $display("FAIL sh_0x12 lat=%0d ram=%h exp 3 de55a5c3", lat, ram[4]);
        end
    endtask

    task automatic test_store_word;
        int lat, nrd, nwr; logic [31:0] d; logic e;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h01234567, lat, d, e, nrd, nwr);
        @(negedge CLK);
        checks++;
        if (lat !== 2 || e !== 1'b0 || nrd !== 0 || nwr !== 1 || ram[4] !== 32'h01234567) begin
            errors++;
            $display("FAIL sw_0x10 lat=%0d err=%b rd=%0d wr=%0d ram=%h exp 2 0 0 1 01234567",
                     lat, e, nrd, nwr, ram[4]);
        end
    endtask

    task automatic test_errors;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h11, 32'h13, 32'h10, 32'd1024};
        int lat, nrd, nwr; logic [31:0] d; logic e;
        for (int i = 0; i < 4; i++) begin
            do_req(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat, d, e, nrd, nwr);
            checks++;
            if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || nrd !== 0 || nwr !== 0) begin
                errors++;
                $display("FAIL err_%0d lat=%0d err=%b data=%h rd=%0d wr=%0d exp 1 1 0 0 0",
                         i, lat, e, d, nrd, nwr);
            end
        end
        checks++;
        if (ram[4] !== 32'h01234567) begin
            errors++; $display("FAIL err_ram got %h exp 01234567", ram[4]);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, nrd, nwr, wr0, seen; logic [31:0] d; logic e;
        @(negedge CLK);
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'hAA;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (mem_memwrite !== 1'b1) begin
            errors++; $display("FAIL rst_wr_setup memwrite=%b exp 1", mem_memwrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_memwrite !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_drop memwrite=%b ready=%b addr=%h exp 0 0 0",
                     mem_memwrite, req_ready, mem_addr);
        end
        seen = 0;
        repeat (2) begin
            @(negedge CLK);
            if (resp_valid) seen++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0 || wr_cnt !== wr0 || ram[4] !== 32'h01234567 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort resp_seen=%0d writes=%0d ram=%h ready=%b exp 0 0 01234567 1",
                     seen, wr_cnt - wr0, ram[4], req_ready);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, d, e, nrd, nwr);
        checks++;
        if (lat !== 2 || d !== 32'h01234567 || e !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_reset lat=%0d data=%h err=%b exp 2 01234567 0", lat, d, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_load_word;
        test_loads;
        test_store_byte;
        test_store_word;
        test_errors;
        test_reset_mid_write;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
